// File: rtl/mixcolumns_iter_if.sv
// Handshake bundle between shiftrows, mixcolumns_iter and AddRoundKey.
//   in_valid/in_ready/state_in/last_round : upstream ShiftRows channel
//   out_valid/out_ready/state_out         : downstream AddRoundKey channel
// master = the environment around the block, slave = mixcolumns_iter.
interface mixcolumns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, last_round, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, last_round, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns: one 32-bit column per clock through a single
// shared GF(2^8) column unit; last_round bypasses the transform.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of mixcolumns_iter_if (valid/ready in and out)
// Column c occupies bits [127-32c -: 32]; the row-0 byte is the column MSB.
module mixcolumns_iter (
  input logic             clk,
  input logic             rst,
  mixcolumns_iter_if.slave bus
);

  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               out_valid_q, out_valid_d;
  logic [COL_W-1:0]   col_sel;
  logic [COL_W-1:0]   col_mix;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; 3*b is expressed as xt(b) ^ b.
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    r0 = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
    r1 = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
    r2 = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
    r3 = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
    return {r0, r1, r2, r3};
  endfunction

  // Column select feeding the shared column unit.
  always_comb begin
    col_sel = work_q[127:96];
    case (col_q)
      2'd0:    col_sel = work_q[127:96];
      2'd1:    col_sel = work_q[95:64];
      2'd2:    col_sel = work_q[63:32];
      default: col_sel = work_q[31:0];
    endcase
  end

  assign col_mix = mix_col(col_sel);

  // Held low during reset so nothing is offered an accept while rst is high.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = work_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          work_d = bus.state_in;
          col_d  = 2'd0;
          if (bus.last_round) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        case (col_q)
          2'd0:    work_d[127:96] = col_mix;
          2'd1:    work_d[95:64]  = col_mix;
          2'd2:    work_d[63:32]  = col_mix;
          default: work_d[31:0]   = col_mix;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Self-checking bench for mixcolumns_iter: directed FIPS-197/column/bypass,
// backpressure and mid-operation reset steps, then a random stream compared
// against a GF(2^8) matrix-multiply reference model.
module tb_mixcolumns_iter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mixcolumns_iter_if bus ();

  mixcolumns_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply (shift-and-add), independent of the RTL's xt form.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Reference: each column multiplied by the circulant matrix (2 3 1 1).
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic lr);
    logic [7:0]   b[16];
    logic [7:0]   r[16];
    logic [7:0]   acc;
    logic [127:0] o;
    int           coef[4];
    coef = '{2, 3, 1, 1};
    if (lr) return s;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(8'(coef[(k - row + 4) % 4]), b[4*c+k]);
        r[4*c+row] = acc;
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = r[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready_timeout"}, 128'(bus.in_ready), 128'd1);
  endtask

  // Present a state and return just after the accepting edge.
  task automatic accept(input string tag, input logic [127:0] data, input logic lr);
    bus.state_in   = data;
    bus.last_round = lr;
    bus.in_valid   = 1'b1;
    wait_ready(tag);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [127:0] data, input logic lr,
                         input logic [127:0] exp);
    int lat;
    accept(tag, data, lr);
    chk({tag, "_in_ready_low"}, 128'(bus.in_ready), 128'd0);
    wait_valid(lat);
    chk({tag, "_latency"}, 128'(lat), lr ? 128'd0 : 128'd4);
    chk({tag, "_data"}, bus.state_out, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_cleared"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_ready_after"}, 128'(bus.in_ready), 128'd1);
  endtask

  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [127:0] held;
  logic [127:0] rnd;
  logic         lr_r;
  logic         seen;
  int           lat;

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.state_in   = '0;
    bus.last_round = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_state_out", bus.state_out, 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(bus.in_ready), 128'd1);
    step();

    // Directed vectors
    run_txn("fips_r1", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
            128'h046681e5_e0cb199a_48f8d37a_2806264c);
    run_txn("colvec", 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    run_txn("bypass", 128'hdb135345_f20a225c_01010101_2d26314c, 1'b1,
            128'hdb135345_f20a225c_01010101_2d26314c);
    chk("model_fips", ref_mix(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0),
        128'h046681e5_e0cb199a_48f8d37a_2806264c);

    // A few random single transactions
    for (int i = 0; i < 4; i++) begin
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      lr_r = 1'($urandom_range(0, 1));
      run_txn("rand_single", rnd, lr_r, ref_mix(rnd, lr_r));
    end

    // Backpressure
    rnd = {$urandom, $urandom, $urandom, $urandom};
    accept("bp", rnd, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 128'(lat), 128'd4);
    chk("bp_data", bus.state_out, ref_mix(rnd, 1'b0));
    held           = bus.state_out;
    bus.state_in   = ~rnd;
    bus.last_round = 1'b1;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_hold_data", bus.state_out, held);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_handshake", 128'(bus.out_valid), 128'd0);
    chk("bp_ready_next", 128'(bus.in_ready), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.out_valid || !bus.in_ready) seen = 1'b1;
    end
    chk("bp_no_extra", 128'(seen), 128'd0);

    // Reset mid-operation
    rnd = {$urandom, $urandom, $urandom, $urandom};
    accept("mid_rst", rnd, 1'b0);
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_state_out", bus.state_out, 128'd0);
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_rel_ready", 128'(bus.in_ready), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_stale", 128'(seen), 128'd0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_txn("post_rst", rnd, 1'b0, ref_mix(rnd, 1'b0));

    // Back-to-back stream with out_ready held high
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rnd  = {$urandom, $urandom, $urandom, $urandom};
          lr_r = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
          exp_q.push_back(ref_mix(rnd, lr_r));
          accept("stream", rnd, lr_r);
        end
      end
      begin
        for (int n = 0; n < 80; n++) begin
          step();
          if (bus.out_valid) got_q.push_back(bus.state_out);
        end
      end
    join
    bus.out_ready = 1'b0;
    chk("stream_count", 128'(got_q.size()), 128'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) chk("stream_data", got_q[i], exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
